inert_ctrl: RTL and testbench
=============================

INERT_CTRL -- requirements
Module: inert_ctrl

Interface
REQ-001 SHALL have parameter INIT_WAIT_W, default 16, meaning width of the power-up wait timer; the wait is 2^INIT_WAIT_W-1 clk cycles.
REQ-002 SHALL have port clk  input  1  system clock; all flops rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port INT  input  1  IMU data-ready, asynchronous to clk, active-high level.
REQ-005 SHALL have port spi_wrt  output  1  one-cycle start pulse to the SPI monarch.
REQ-006 SHALL have port spi_cmd  output  16  command/data word for the SPI monarch; [15:8] register address (bit15=1 read), [7:0] write data.
REQ-007 SHALL have port spi_done  input  1  SPI monarch transaction-complete level.
REQ-008 SHALL have port spi_rd  input  16  SPI monarch read data; only [7:0] is used.
REQ-009 SHALL have port init_done  output  1  high once the configuration writes have completed.
REQ-010 SHALL have port ptch_rt  output  16  signed pitch rate, {high byte, low byte}.
REQ-011 SHALL have port AZ  output  16  signed Z acceleration, {high byte, low byte}.
REQ-012 SHALL have port vld  output  1  one-cycle pulse when ptch_rt and AZ update.

Function
REQ-013 SHALL be an FSM with states PWR_WAIT, CFG_SEND, CFG_WAIT, WAIT_INT, RD_SEND, RD_WAIT.
REQ-014 PWR_WAIT SHALL count a free-running INIT_WAIT_W-bit timer from 0 and go to CFG_SEND when the timer is all ones.
REQ-015 In CFG_SEND, the controller SHALL pulse spi_wrt for exactly one cycle, with spi_cmd = CFG[idx], and then go to CFG_WAIT. The table is CFG[0..3] = 0x0D02, 0x1053, 0x1150, 0x1460.
REQ-016 CFG_WAIT SHALL ignore spi_done in the cycle following spi_wrt and return to CFG_SEND with idx+1 on spi_done=1.
REQ-017 After idx=3 completes, the FSM SHALL go to WAIT_INT with idx=0.
REQ-018 init_done SHALL be set on entry to WAIT_INT and remain set until reset.
REQ-019 INT SHALL pass through a two-flop synchronizer; WAIT_INT SHALL go to RD_SEND when the synchronized INT is 1 (level-sensitive).
REQ-020 RD_SEND/RD_WAIT SHALL issue RD[0..3] = 0xA200, 0xA300, 0xAC00, 0xAD00 in order, using the same pulse/wait rule as the configuration writes.
REQ-021 On each read done, spi_rd[7:0] SHALL be captured into the matching byte holding register (ptch_L, ptch_H, AZ_L, AZ_H).
REQ-022 The cycle after the fourth read done, ptch_rt and AZ SHALL load together from the holding registers, vld SHALL pulse for 1 cycle, and the FSM SHALL return to WAIT_INT.
REQ-023 ptch_rt and AZ SHALL hold their values between vld pulses; a partially completed read set SHALL never reach the outputs.
REQ-024 If INT is still high on return to WAIT_INT, a new read set SHALL start immediately (back-to-back).
REQ-025 Exactly one SPI transaction SHALL be outstanding at a time; spi_wrt SHALL never assert outside CFG_SEND or RD_SEND.
REQ-026 spi_cmd SHALL hold its value from the spi_wrt cycle until the next spi_wrt.
REQ-027 The 2-bit idx counter SHALL reset to 0 on each state-group change and SHALL not wrap within a group.
REQ-028 INT changes during a read set SHALL be ignored until the FSM returns to WAIT_INT.

Reset
REQ-029 Asserting rst_n low SHALL immediately force the following, at any point including mid-transaction: state=PWR_WAIT, timer=0, idx=0, spi_wrt=0, spi_cmd=0x0000, init_done=0, ptch_rt=0, AZ=0, vld=0, holding registers=0, synchronizer flops=0.
REQ-030 After reset release, the full power-up wait and configuration sequence SHALL repeat.

Structure
REQ-031 The state enum and the CFG/RD command constant tables SHALL live in a shared package (inert_pkg).
REQ-032 The INT double-flop synchronizer SHALL be a separate sub-module (sync2); the SPI monarch is external and connected at the parent level.

Verification
REQ-033 Release reset with INIT_WAIT_W=16 -> spi_wrt first asserts 65535 cycles later with spi_cmd=0x0D02.
REQ-034 Model spi_done 40 cycles after each spi_wrt -> commands 0x0D02, 0x1053, 0x1150, 0x1460 in order, then init_done=1 and no further spi_wrt while INT=0.
REQ-035 Raise INT, return bytes 0x34, 0x12, 0x78, 0xF6 -> ptch_rt=0x1234, AZ=0xF678, single-cycle vld.
REQ-036 Hold INT high for 3 read sets -> 12 reads back-to-back, 3 vld pulses, outputs change only on vld.
REQ-037 Assert rst_n mid-way through the third read of a set -> all outputs 0 at once; after release the power-up wait and 4 configuration writes repeat, and no stale bytes appear.
REQ-038 Toggle INT during RD_WAIT -> read order is unaffected and exactly one vld pulse is produced per completed set.

Source files
------------

// File: rtl/inert_pkg.sv
`default_nettype none
// ============================================================================
// Package     : inert_pkg
// Description : Shared types and SPI command tables for the inertial sensor
//               controller (state encoding, configuration and read commands).
// Revision    : 1.0 - initial release
// ============================================================================
package inert_pkg;

   typedef enum logic [2:0] {
      PWR_WAIT = 3'd0,
      CFG_SEND = 3'd1,
      CFG_WAIT = 3'd2,
      WAIT_INT = 3'd3,
      RD_SEND  = 3'd4,
      RD_WAIT  = 3'd5
   } state_t;

   localparam logic [1:0] LAST_IDX = 2'd3;

   // Configuration writes issued once after power-up, in order.
   function automatic logic [15:0] cfg_cmd(input logic [1:0] idx);
      logic [15:0] cmd;
      case (idx)
         2'd0:    cmd = 16'h0D02;
         2'd1:    cmd = 16'h1053;
         2'd2:    cmd = 16'h1150;
         default: cmd = 16'h1460;
      endcase
      return cmd;
   endfunction

   // Data reads: pitch low, pitch high, AZ low, AZ high (bit15 = read).
   function automatic logic [15:0] rd_cmd(input logic [1:0] idx);
      logic [15:0] cmd;
      case (idx)
         2'd0:    cmd = 16'hA200;
         2'd1:    cmd = 16'hA300;
         2'd2:    cmd = 16'hAC00;
         default: cmd = 16'hAD00;
      endcase
      return cmd;
   endfunction

endpackage
`default_nettype wire

// File: rtl/inert_ctrl_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Two-flop synchronizer for a single asynchronous level.
// Revision    : 1.0 - initial release
// Ports       : clk      - destination clock
//               rst_n    - asynchronous active-low reset (flops clear to 0)
//               async_in - level from another clock domain
//               sync_out - level synchronized to clk
// ============================================================================
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_out
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = async_in;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign sync_out = sync_q;

endmodule
`default_nettype wire

// File: rtl/inert_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : inert_ctrl
// Description : Inertial sensor controller. Waits out the sensor power-up,
//               writes four configuration registers over an external SPI
//               monarch, then on each data-ready reads pitch rate and Z
//               acceleration (4 bytes) and publishes them atomically.
// Revision    : 1.0 - initial release
// Ports       : clk       - system clock, rising edge
//               rst_n     - asynchronous active-low reset
//               INT       - sensor data-ready, asynchronous level
//               spi_wrt   - one-cycle transaction start to SPI monarch
//               spi_cmd   - SPI command word {addr, wdata}
//               spi_done  - SPI transaction-complete level
//               spi_rd    - SPI read data (low byte used)
//               init_done - configuration complete
//               ptch_rt   - signed pitch rate
//               AZ        - signed Z acceleration
//               vld       - one-cycle pulse when ptch_rt/AZ update
// ============================================================================
module inert_ctrl
   import inert_pkg::*;
#(
   parameter int INIT_WAIT_W = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        INT,
   output logic        spi_wrt,
   output logic [15:0] spi_cmd,
   input  logic        spi_done,
   input  logic [15:0] spi_rd,
   output logic        init_done,
   output logic [15:0] ptch_rt,
   output logic [15:0] AZ,
   output logic        vld
);

   state_t                 state_q, state_d;
   logic [INIT_WAIT_W-1:0] timer_q, timer_d;
   logic [1:0]             idx_q, idx_d;
   logic                   ign_q, ign_d;
   logic                   spi_wrt_q, spi_wrt_d;
   logic [15:0]            spi_cmd_q, spi_cmd_d;
   logic                   init_done_q, init_done_d;
   logic [15:0]            ptch_rt_q, ptch_rt_d;
   logic [15:0]            az_q, az_d;
   logic                   vld_q, vld_d;
   logic [7:0]             ptch_l_q, ptch_l_d;
   logic [7:0]             ptch_h_q, ptch_h_d;
   logic [7:0]             az_l_q, az_l_d;
   logic                   int_sync;
   logic                   done_ok;
   logic [7:0]             unused_rd_hi;

   assign unused_rd_hi = spi_rd[15:8];

   sync2 u_int_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (INT),
      .sync_out (int_sync)
   );

   // The monarch may still show done from the previous transaction in the
   // cycle right after spi_wrt, so that cycle's done is not trusted.
   assign done_ok = spi_done & ~ign_q;

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q + 1'b1;
      idx_d       = idx_q;
      spi_cmd_d   = spi_cmd_q;
      init_done_d = init_done_q;
      ptch_rt_d   = ptch_rt_q;
      az_d        = az_q;
      vld_d       = 1'b0;
      ptch_l_d    = ptch_l_q;
      ptch_h_d    = ptch_h_q;
      az_l_d      = az_l_q;
      ign_d       = (state_q == CFG_SEND) || (state_q == RD_SEND);

      case (state_q)
         PWR_WAIT: begin
            // Leave on the same edge the timer reaches all ones.
            if (&timer_d) begin
               state_d = CFG_SEND;
               idx_d   = 2'd0;
            end
         end
         CFG_SEND: state_d = CFG_WAIT;
         CFG_WAIT: begin
            if (done_ok) begin
               if (idx_q == LAST_IDX) begin
                  state_d     = WAIT_INT;
                  idx_d       = 2'd0;
                  init_done_d = 1'b1;
               end else begin
                  state_d = CFG_SEND;
                  idx_d   = idx_q + 2'd1;
               end
            end
         end
         WAIT_INT: begin
            if (int_sync) begin
               state_d = RD_SEND;
               idx_d   = 2'd0;
            end
         end
         RD_SEND: state_d = RD_WAIT;
         RD_WAIT: begin
            if (done_ok) begin
               case (idx_q)
                  2'd0:    ptch_l_d = spi_rd[7:0];
                  2'd1:    ptch_h_d = spi_rd[7:0];
                  2'd2:    az_l_d   = spi_rd[7:0];
                  default: ;
               endcase
               if (idx_q == LAST_IDX) begin
                  // AZ high byte goes straight to the output so both words
                  // appear together in the cycle after the last done.
                  state_d   = WAIT_INT;
                  idx_d     = 2'd0;
                  ptch_rt_d = {ptch_h_q, ptch_l_q};
                  az_d      = {spi_rd[7:0], az_l_q};
                  vld_d     = 1'b1;
               end else begin
                  state_d = RD_SEND;
                  idx_d   = idx_q + 2'd1;
               end
            end
         end
         default: begin
            state_d = PWR_WAIT;
            idx_d   = 2'd0;
         end
      endcase

      // Start pulse and command are registered alongside the state, so they
      // coincide exactly with the SEND state cycle.
      spi_wrt_d = (state_d == CFG_SEND) || (state_d == RD_SEND);
      if (state_d == CFG_SEND) begin
         spi_cmd_d = cfg_cmd(idx_d);
      end else if (state_d == RD_SEND) begin
         spi_cmd_d = rd_cmd(idx_d);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= PWR_WAIT;
         timer_q     <= '0;
         idx_q       <= 2'd0;
         ign_q       <= 1'b0;
         spi_wrt_q   <= 1'b0;
         spi_cmd_q   <= 16'h0000;
         init_done_q <= 1'b0;
         ptch_rt_q   <= 16'h0000;
         az_q        <= 16'h0000;
         vld_q       <= 1'b0;
         ptch_l_q    <= 8'h00;
         ptch_h_q    <= 8'h00;
         az_l_q      <= 8'h00;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         idx_q       <= idx_d;
         ign_q       <= ign_d;
         spi_wrt_q   <= spi_wrt_d;
         spi_cmd_q   <= spi_cmd_d;
         init_done_q <= init_done_d;
         ptch_rt_q   <= ptch_rt_d;
         az_q        <= az_d;
         vld_q       <= vld_d;
         ptch_l_q    <= ptch_l_d;
         ptch_h_q    <= ptch_h_d;
         az_l_q      <= az_l_d;
      end
   end

   assign spi_wrt   = spi_wrt_q;
   assign spi_cmd   = spi_cmd_q;
   assign init_done = init_done_q;
   assign ptch_rt   = ptch_rt_q;
   assign AZ        = az_q;
   assign vld       = vld_q;

endmodule
`default_nettype wire

// File: tb/tb_inert_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_inert_ctrl
// Description : Directed self-checking bench for inert_ctrl with a behavioural
//               SPI monarch responder (done level after a fixed delay).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inert_ctrl;

   localparam int W        = 6;
   localparam int WAIT_CYC = (1 << W) - 1;
   localparam int DONE_DLY = 40;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        INT = 1'b0;
   logic        spi_done = 1'b0;
   logic [15:0] spi_rd = 16'h0000;
   logic        spi_wrt;
   logic [15:0] spi_cmd;
   logic        init_done;
   logic [15:0] ptch_rt;
   logic [15:0] AZ;
   logic        vld;

   always #5 clk = ~clk;

   inert_ctrl #(.INIT_WAIT_W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .INT       (INT),
      .spi_wrt   (spi_wrt),
      .spi_cmd   (spi_cmd),
      .spi_done  (spi_done),
      .spi_rd    (spi_rd),
      .init_done (init_done),
      .ptch_rt   (ptch_rt),
      .AZ        (AZ),
      .vld       (vld)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] cmd_log[$];
   logic [31:0] vld_log[$];
   logic [7:0]  rd_bytes [0:31];
   int          rd_cnt = 0;
   logic [15:0] cfg_exp [0:3] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
   logic [15:0] rd_exp  [0:3] = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // SPI monarch model: logs each command, raises done DONE_DLY cycles later
   // and keeps it high until the cycle after the next spi_wrt.
   logic        busy = 1'b0;
   logic        wrt_prev = 1'b0;
   int          cnt = 0;
   logic [15:0] cur_cmd = 16'h0000;

   always @(negedge clk) begin
      if (!rst_n) begin
         spi_done = 1'b0;
         busy     = 1'b0;
         cnt      = 0;
         wrt_prev = 1'b0;
         rd_cnt   = (rd_cnt + 3) & ~3;
      end else begin
         if (wrt_prev) spi_done = 1'b0;
         if (spi_wrt) begin
            check("one_outstanding", {31'b0, busy}, 32'd0);
            busy    = 1'b1;
            cnt     = DONE_DLY;
            cur_cmd = spi_cmd;
            cmd_log.push_back(spi_cmd);
         end else if (busy) begin
            cnt--;
            if (cnt == 0) begin
               busy     = 1'b0;
               spi_done = 1'b1;
               if (cur_cmd[15]) begin
                  spi_rd = {8'hEE, rd_bytes[rd_cnt[4:0]]};
                  rd_cnt++;
               end else begin
                  spi_rd = 16'hC0DE;
               end
            end
         end
         wrt_prev = spi_wrt;
      end
   end

   // Output monitor: record every vld sample, flag any change without vld.
   logic [31:0] prev_out = 32'h0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (vld) vld_log.push_back({ptch_rt, AZ});
         else if ({ptch_rt, AZ} !== prev_out)
            check("hold_between_vld", {ptch_rt, AZ}, prev_out);
      end
      prev_out = {ptch_rt, AZ};
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wait_log(input int n, input int budget, input string tag);
      int k = 0;
      while (cmd_log.size() < n && k < budget) begin
         @(negedge clk); #1; k++;
      end
      if (cmd_log.size() < n) check(tag, cmd_log.size(), n);
   endtask

   task automatic wait_vld(input int n, input int budget, input string tag);
      int k = 0;
      while (vld_log.size() < n && k < budget) begin
         @(negedge clk); #1; k++;
      end
      if (vld_log.size() < n) check(tag, vld_log.size(), n);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_spi_wrt"},   {31'b0, spi_wrt},   32'd0);
      check({tag, "_spi_cmd"},   {16'b0, spi_cmd},   32'd0);
      check({tag, "_init_done"}, {31'b0, init_done}, 32'd0);
      check({tag, "_ptch_rt"},   {16'b0, ptch_rt},   32'd0);
      check({tag, "_AZ"},        {16'b0, AZ},        32'd0);
      check({tag, "_vld"},       {31'b0, vld},       32'd0);
   endtask

   // Release reset, time the power-up wait, verify the four config writes.
   task automatic power_up();
      int n = 0;
      int base;
      int k = 0;
      base = cmd_log.size();
      @(negedge clk);
      rst_n = 1'b1;
      do begin
         @(posedge clk); #1; n++;
      end while (!spi_wrt && n < WAIT_CYC + 50);
      check("pwr_wait_cycles", n, WAIT_CYC);
      check("first_cmd", {16'b0, spi_cmd}, 32'h0D02);
      wait_log(base + 4, 4 * (DONE_DLY + 10), "cfg_timeout");
      for (int i = 0; i < 4; i++)
         if (base + i < cmd_log.size())
            check($sformatf("cfg_cmd%0d", i), {16'b0, cmd_log[base + i]}, {16'b0, cfg_exp[i]});
      while (!init_done && k < DONE_DLY + 10) begin
         @(negedge clk); #1; k++;
      end
      check("init_done", {31'b0, init_done}, 32'd1);
      check("ptch_after_init", {16'b0, ptch_rt}, 32'd0);
      check("AZ_after_init", {16'b0, AZ}, 32'd0);
      cycles(200);
      check("idle_no_wrt", cmd_log.size(), base + 4);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      int v;
      logic [31:0] exp3 [0:2] = '{32'h0201_0403, 32'hA211_8433, 32'h7FFF_8000};
      logic [7:0]  bytes [0:27] = '{8'h34, 8'h12, 8'h78, 8'hF6,
                                    8'h01, 8'h02, 8'h03, 8'h04,
                                    8'h11, 8'hA2, 8'h33, 8'h84,
                                    8'hFF, 8'h7F, 8'h00, 8'h80,
                                    8'h5A, 8'hC3, 8'h0F, 8'hE1,
                                    8'hAA, 8'hBB, 8'hCC, 8'hDD,
                                    8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 32; i++) rd_bytes[i] = (i < 28) ? bytes[i] : 8'h00;

      // Reset state
      cycles(3);
      check_zero_outputs("reset");

      // Power-up wait and configuration
      power_up();

      // Single read set
      b = cmd_log.size(); v = vld_log.size();
      INT = 1'b1;
      wait_log(b + 1, 100, "rd1_start_timeout");
      INT = 1'b0;
      wait_vld(v + 1, 400, "rd1_vld_timeout");
      check("rd1_ptch", {16'b0, ptch_rt}, 32'h1234);
      check("rd1_AZ", {16'b0, AZ}, 32'hF678);
      cycles(1);
      check("rd1_vld_one_cycle", {31'b0, vld}, 32'd0);
      cycles(200);
      check("rd1_reads", cmd_log.size(), b + 4);
      check("rd1_vld_count", vld_log.size(), v + 1);
      for (int i = 0; i < 4; i++)
         if (b + i < cmd_log.size())
            check($sformatf("rd1_cmd%0d", i), {16'b0, cmd_log[b + i]}, {16'b0, rd_exp[i]});

      // Three back-to-back sets with INT held high
      b = cmd_log.size(); v = vld_log.size();
      INT = 1'b1;
      wait_log(b + 9, 1500, "rd3_start_timeout");
      INT = 1'b0;
      wait_vld(v + 3, 800, "rd3_vld_timeout");
      cycles(200);
      check("rd3_reads", cmd_log.size(), b + 12);
      check("rd3_vld_count", vld_log.size(), v + 3);
      for (int i = 0; i < 12; i++)
         if (b + i < cmd_log.size())
            check($sformatf("rd3_cmd%0d", i), {16'b0, cmd_log[b + i]}, {16'b0, rd_exp[i % 4]});
      for (int k = 0; k < 3; k++)
         if (v + k < vld_log.size())
            check($sformatf("rd3_out%0d", k), vld_log[v + k], exp3[k]);

      // INT toggling while a set is in flight
      b = cmd_log.size(); v = vld_log.size();
      INT = 1'b1;
      wait_log(b + 1, 100, "tog_start_timeout");
      repeat (13) begin
         cycles(3);
         INT = ~INT;
      end
      INT = 1'b0;
      wait_vld(v + 1, 400, "tog_vld_timeout");
      cycles(200);
      check("tog_reads", cmd_log.size(), b + 4);
      check("tog_vld_count", vld_log.size(), v + 1);
      check("tog_out", {ptch_rt, AZ}, 32'hC35A_E10F);
      for (int i = 0; i < 4; i++)
         if (b + i < cmd_log.size())
            check($sformatf("tog_cmd%0d", i), {16'b0, cmd_log[b + i]}, {16'b0, rd_exp[i]});

      // Reset in the middle of the third read
      b = cmd_log.size(); v = vld_log.size();
      INT = 1'b1;
      wait_log(b + 3, 300, "mid_start_timeout");
      INT = 1'b0;
      cycles(10);
      #1;
      rst_n = 1'b0;
      #1;
      check_zero_outputs("midreset");
      cycles(3);
      check("midreset_no_vld", vld_log.size(), v);
      power_up();

      // A fresh set after the re-initialisation
      b = cmd_log.size(); v = vld_log.size();
      INT = 1'b1;
      wait_log(b + 1, 100, "post_start_timeout");
      INT = 1'b0;
      wait_vld(v + 1, 400, "post_vld_timeout");
      check("post_out", {ptch_rt, AZ}, 32'h2211_4433);
      cycles(100);
      check("post_vld_count", vld_log.size(), v + 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
